// File: rtl/ieeedrv_rom_arb.sv
// ieeedrv_rom_arb: round-robin sharing of one synchronous ROM read port, with download-write priority.
// Define IEEEDRV_ROM_ARB_STATS_EN to add the max_wait request-wait statistic output.
module ieeedrv_rom_arb #(
    parameter int NREQ   = 4,
    parameter int AW     = 15,
    parameter int DW     = 8,
    parameter int RD_LAT = 1
) (
    input  logic               clk_sys,
    input  logic               reset,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*AW-1:0] req_addr,
    output logic [NREQ-1:0]    ack,
    output logic [NREQ*DW-1:0] rdata,
    output logic [NREQ-1:0]    pending,
    output logic [AW-1:0]      rom_addr,
    output logic               rom_rd,
    input  logic [DW-1:0]      rom_q,
    output logic               rom_we,
    output logic [DW-1:0]      rom_wdata,
    input  logic               load_wr,
    input  logic [AW-1:0]      load_addr,
    input  logic [DW-1:0]      load_data,
    output logic               busy
`ifdef IEEEDRV_ROM_ARB_STATS_EN
    , output logic [7:0]       max_wait
`endif
);
    localparam int IW = $clog2(NREQ);

    logic [AW-1:0]   addr_q [NREQ];
    logic [IW-1:0]   rr;
    logic [IW-1:0]   gnt;
    logic            gnt_v;
    logic            issue;
    logic [NREQ-1:0] accept;
    logic [NREQ-1:0] inflight;
    logic [RD_LAT:0] pv;
    logic [IW-1:0]   pidx [RD_LAT+1];

    // Lowest pending index overall, overridden by the lowest one at or after rr.
    always_comb begin
        gnt = '0;
        for (int i = NREQ - 1; i >= 0; i--)
            if (pending[i]) gnt = IW'(i);
        for (int i = NREQ - 1; i >= 0; i--)
            if (pending[i] && IW'(i) >= rr) gnt = IW'(i);
        inflight = '0;
        for (int i = 0; i < NREQ; i++)
            for (int k = 0; k <= RD_LAT; k++)
                if (pv[k] && pidx[k] == IW'(i)) inflight[i] = 1'b1;
    end

    assign gnt_v  = |pending;
    assign issue  = gnt_v && !load_wr;
    assign accept = req & ~pending & ~inflight;
    assign busy   = |{pending, pv};

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            pending   <= '0;
            rr        <= '0;
            rom_rd    <= 1'b0;
            rom_we    <= 1'b0;
            rom_addr  <= '0;
            rom_wdata <= '0;
            ack       <= '0;
            rdata     <= '0;
            pv        <= '0;
            for (int k = 0; k <= RD_LAT; k++) pidx[k] <= '0;
            for (int i = 0; i < NREQ; i++) addr_q[i] <= '0;
        end else begin
            rom_we <= load_wr;
            rom_rd <= issue;
            if (load_wr) begin
                rom_addr  <= load_addr;
                rom_wdata <= load_data;
            end else if (issue) begin
                rom_addr <= addr_q[gnt];
            end
            if (issue) rr <= (gnt == IW'(NREQ - 1)) ? '0 : gnt + IW'(1);
            pv      <= {pv[RD_LAT-1:0], issue};
            pidx[0] <= gnt;
            for (int k = 1; k <= RD_LAT; k++) pidx[k] <= pidx[k-1];
            ack <= '0;
            for (int i = 0; i < NREQ; i++) begin
                if (accept[i]) begin
                    pending[i] <= 1'b1;
                    addr_q[i]  <= req_addr[i*AW +: AW];
                end else if (issue && gnt == IW'(i)) begin
                    pending[i] <= 1'b0;
                end
                if (pv[RD_LAT] && pidx[RD_LAT] == IW'(i)) begin
                    ack[i]             <= 1'b1;
                    rdata[i*DW +: DW]  <= rom_q;
                end
            end
        end
    end

`ifdef IEEEDRV_ROM_ARB_STATS_EN
    logic [7:0] wcnt [NREQ];

    // A counter holds the cycles spent pending before the grant cycle.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            max_wait <= '0;
            for (int i = 0; i < NREQ; i++) wcnt[i] <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (accept[i])
                    wcnt[i] <= '0;
                else if (pending[i] && !(issue && gnt == IW'(i)) && wcnt[i] != 8'hff)
                    wcnt[i] <= wcnt[i] + 8'd1;
            end
            if (issue && wcnt[gnt] > max_wait) max_wait <= wcnt[gnt];
        end
    end
`endif
endmodule

// File: tb/tb_ieeedrv_rom_arb.sv
// tb_ieeedrv_rom_arb: directed cycle-level bench for ieeedrv_rom_arb with a one-cycle-latency ROM.
module tb_ieeedrv_rom_arb;
    localparam int NREQ = 4;
    localparam int AW   = 15;
    localparam int DW   = 8;

    logic               clk_sys = 1'b0;
    logic               reset   = 1'b1;
    logic [NREQ-1:0]    req     = '0;
    logic [NREQ*AW-1:0] req_addr = '0;
    logic [NREQ-1:0]    ack;
    logic [NREQ*DW-1:0] rdata;
    logic [NREQ-1:0]    pending;
    logic [AW-1:0]      rom_addr;
    logic               rom_rd;
    logic [DW-1:0]      rom_q = '0;
    logic               rom_we;
    logic [DW-1:0]      rom_wdata;
    logic               load_wr   = 1'b0;
    logic [AW-1:0]      load_addr = '0;
    logic [DW-1:0]      load_data = '0;
    logic               busy;
`ifdef IEEEDRV_ROM_ARB_STATS_EN
    logic [7:0]         max_wait;
`endif

    int errs   = 0;
    int checks = 0;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    ieeedrv_rom_arb #(.NREQ(NREQ), .AW(AW), .DW(DW), .RD_LAT(1)) dut (
        .clk_sys(clk_sys), .reset(reset), .req(req), .req_addr(req_addr),
        .ack(ack), .rdata(rdata), .pending(pending), .rom_addr(rom_addr),
        .rom_rd(rom_rd), .rom_q(rom_q), .rom_we(rom_we), .rom_wdata(rom_wdata),
        .load_wr(load_wr), .load_addr(load_addr), .load_data(load_data), .busy(busy)
`ifdef IEEEDRV_ROM_ARB_STATS_EN
        , .max_wait(max_wait)
`endif
    );

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) begin
        if (rom_we) mem[rom_addr] <= rom_wdata;
        if (rom_rd) rom_q <= mem[rom_addr];
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a);
        req[i] = 1'b1;
        req_addr[i*AW +: AW] = a;
    endtask

    function automatic logic [DW-1:0] rd(input int i);
        return rdata[i*DW +: DW];
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        checks++; if ({ack, pending, rom_rd, rom_we, busy} !== '0) begin errs++; $display("FAIL reset_ctl: got %b want 0", {ack, pending, rom_rd, rom_we, busy}); end
        checks++; if (rdata !== '0) begin errs++; $display("FAIL reset_rdata: got %h want 0", rdata); end
        checks++; if ({rom_addr, rom_wdata} !== '0) begin errs++; $display("FAIL reset_rom: got %h want 0", {rom_addr, rom_wdata}); end
`ifdef IEEEDRV_ROM_ARB_STATS_EN
        checks++; if (max_wait !== 8'd0) begin errs++; $display("FAIL reset_max_wait: got %0d want 0", max_wait); end
`endif
    endtask

    task automatic preload();
        logic [AW-1:0] a [5] = '{15'h1234, 15'h100, 15'h101, 15'h102, 15'h103};
        logic [DW-1:0] d [5] = '{8'hA5, 8'h10, 8'h11, 8'h12, 8'h13};
        for (int i = 0; i < 5; i++) begin
            load_wr = 1'b1; load_addr = a[i]; load_data = d[i];
            tick();
        end
        load_wr = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_single();
        set_req(0, 15'h1234);
        tick();
        req = '0;
        checks++; if (pending !== 4'b0001 || busy !== 1'b1) begin errs++; $display("FAIL single_pending: got %b/%b want 0001/1", pending, busy); end
        tick();
        checks++; if (rom_rd !== 1'b1 || rom_addr !== 15'h1234) begin errs++; $display("FAIL single_issue: got rd=%b addr=%h want 1/1234", rom_rd, rom_addr); end
        tick();
        checks++; if (ack !== 4'b0000) begin errs++; $display("FAIL single_early_ack: got %b want 0000", ack); end
        tick();
        checks++; if (ack !== 4'b0001 || rd(0) !== 8'hA5) begin errs++; $display("FAIL single_ack: got %b/%h want 0001/a5", ack, rd(0)); end
        tick();
        checks++; if (ack !== 4'b0000 || rd(0) !== 8'hA5) begin errs++; $display("FAIL single_hold: got %b/%h want 0000/a5", ack, rd(0)); end
        tick();
    endtask

    task automatic test_contention();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < NREQ; i++) set_req(i, AW'(32'h100 + i));
        tick();
        req = '0;
        checks++; if (pending !== 4'b1111) begin errs++; $display("FAIL cont_pending: got %b want 1111", pending); end
        tick();
        for (int c = 2; c <= 7; c++) begin
            if (c <= 5) begin
                checks++; if (rom_rd !== 1'b1 || rom_addr !== AW'(32'h100 + c - 2)) begin errs++; $display("FAIL cont_issue c%0d: got rd=%b addr=%h want 1/%h", c, rom_rd, rom_addr, 32'h100 + c - 2); end
            end
            if (c >= 4) begin
                checks++; if (ack !== 4'(1 << (c - 4)) || rd(c - 4) !== 8'(8'h10 + c - 4)) begin errs++; $display("FAIL cont_ack c%0d: got %b/%h want %b/%h", c, ack, rd(c - 4), 4'(1 << (c - 4)), 8'(8'h10 + c - 4)); end
            end
            tick();
        end
`ifdef IEEEDRV_ROM_ARB_STATS_EN
        checks++; if (max_wait !== 8'd3) begin errs++; $display("FAIL cont_max_wait: got %0d want 3", max_wait); end
`endif
    endtask

    task automatic test_rr();
        set_req(0, 15'h100); set_req(3, 15'h103);
        tick();
        req = '0;
        checks++; if (pending !== 4'b1001) begin errs++; $display("FAIL rr_pending: got %b want 1001", pending); end
        tick();
        checks++; if (rom_rd !== 1'b1 || rom_addr !== 15'h100) begin errs++; $display("FAIL rr_first: got %b/%h want 1/0100", rom_rd, rom_addr); end
        tick();
        checks++; if (rom_rd !== 1'b1 || rom_addr !== 15'h103) begin errs++; $display("FAIL rr_second: got %b/%h want 1/0103", rom_rd, rom_addr); end
        tick();
        checks++; if (ack !== 4'b0001 || rd(0) !== 8'h10) begin errs++; $display("FAIL rr_ack0: got %b/%h want 0001/10", ack, rd(0)); end
        tick();
        checks++; if (ack !== 4'b1000 || rd(3) !== 8'h13) begin errs++; $display("FAIL rr_ack3: got %b/%h want 1000/13", ack, rd(3)); end
        tick();
        set_req(1, 15'h101);
        tick();
        req = '0;
        tick();
        tick();
        tick();
        checks++; if (ack !== 4'b0010 || rd(1) !== 8'h11) begin errs++; $display("FAIL rr_ack1: got %b/%h want 0010/11", ack, rd(1)); end
        tick();
        set_req(0, 15'h102); set_req(3, 15'h100);
        tick();
        req = '0;
        tick();
        checks++; if (rom_addr !== 15'h100) begin errs++; $display("FAIL rr_rot_first: got %h want 0100", rom_addr); end
        tick();
        checks++; if (rom_addr !== 15'h102) begin errs++; $display("FAIL rr_rot_second: got %h want 0102", rom_addr); end
        tick();
        checks++; if (ack !== 4'b1000 || rd(3) !== 8'h10) begin errs++; $display("FAIL rr_rot_ack3: got %b/%h want 1000/10", ack, rd(3)); end
        tick();
        checks++; if (ack !== 4'b0001 || rd(0) !== 8'h12) begin errs++; $display("FAIL rr_rot_ack0: got %b/%h want 0001/12", ack, rd(0)); end
        tick();
    endtask

    task automatic test_load();
        set_req(1, 15'h202);
        tick();
        req = '0;
        checks++; if (pending !== 4'b0010) begin errs++; $display("FAIL load_pending: got %b want 0010", pending); end
        load_wr = 1'b1; load_addr = 15'h200; load_data = 8'h5A;
        tick();
        checks++; if (rom_we !== 1'b1 || rom_rd !== 1'b0 || rom_addr !== 15'h200 || rom_wdata !== 8'h5A || pending !== 4'b0010) begin errs++; $display("FAIL load_w1: got we=%b rd=%b a=%h d=%h p=%b want 1/0/0200/5a/0010", rom_we, rom_rd, rom_addr, rom_wdata, pending); end
        load_addr = 15'h201; load_data = 8'h5B;
        tick();
        checks++; if (rom_we !== 1'b1 || rom_rd !== 1'b0 || pending !== 4'b0010) begin errs++; $display("FAIL load_w2: got we=%b rd=%b p=%b want 1/0/0010", rom_we, rom_rd, pending); end
        load_addr = 15'h202; load_data = 8'h5C;
        tick();
        load_wr = 1'b0;
        checks++; if (rom_we !== 1'b1 || rom_rd !== 1'b0 || rom_wdata !== 8'h5C) begin errs++; $display("FAIL load_w3: got we=%b rd=%b d=%h want 1/0/5c", rom_we, rom_rd, rom_wdata); end
        tick();
        checks++; if (rom_rd !== 1'b1 || rom_we !== 1'b0 || rom_addr !== 15'h202) begin errs++; $display("FAIL load_read: got rd=%b we=%b a=%h want 1/0/0202", rom_rd, rom_we, rom_addr); end
        tick();
        tick();
        checks++; if (ack !== 4'b0010 || rd(1) !== 8'h5C) begin errs++; $display("FAIL load_ack: got %b/%h want 0010/5c", ack, rd(1)); end
        tick();
    endtask

    task automatic test_rereq();
        set_req(2, 15'h100);
        tick();
        checks++; if (pending !== 4'b0100) begin errs++; $display("FAIL rereq_pending: got %b want 0100", pending); end
        set_req(2, 15'h101);
        tick();
        checks++; if (rom_rd !== 1'b1 || rom_addr !== 15'h100) begin errs++; $display("FAIL rereq_issue: got %b/%h want 1/0100", rom_rd, rom_addr); end
        set_req(2, 15'h102);
        tick();
        req = '0;
        checks++; if (pending !== 4'b0000 || ack !== 4'b0000) begin errs++; $display("FAIL rereq_ignored: got p=%b ack=%b want 0000/0000", pending, ack); end
        tick();
        checks++; if (ack !== 4'b0100 || rd(2) !== 8'h10) begin errs++; $display("FAIL rereq_ack1: got %b/%h want 0100/10", ack, rd(2)); end
        set_req(2, 15'h103);
        tick();
        req = '0;
        checks++; if (ack !== 4'b0000 || pending !== 4'b0100) begin errs++; $display("FAIL rereq_ackcycle: got ack=%b p=%b want 0000/0100", ack, pending); end
        tick();
        checks++; if (rom_rd !== 1'b1 || rom_addr !== 15'h103) begin errs++; $display("FAIL rereq_issue2: got %b/%h want 1/0103", rom_rd, rom_addr); end
        tick();
        tick();
        checks++; if (ack !== 4'b0100 || rd(2) !== 8'h13) begin errs++; $display("FAIL rereq_ack2: got %b/%h want 0100/13", ack, rd(2)); end
        tick();
    endtask

    task automatic test_reset_mid();
        set_req(0, 15'h1234);
        tick();
        req = '0;
        tick();
        checks++; if (rom_rd !== 1'b1) begin errs++; $display("FAIL mid_issue: got %b want 1", rom_rd); end
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (ack !== '0 || pending !== '0 || busy !== 1'b0 || rdata !== '0 || rom_rd !== 1'b0) begin errs++; $display("FAIL mid_cleared: got ack=%b p=%b busy=%b rdata=%h rd=%b want all 0", ack, pending, busy, rdata, rom_rd); end
`ifdef IEEEDRV_ROM_ARB_STATS_EN
        checks++; if (max_wait !== 8'd0) begin errs++; $display("FAIL mid_max_wait: got %0d want 0", max_wait); end
`endif
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++; if (ack !== '0) begin errs++; $display("FAIL mid_no_ack c%0d: got %b want 0000", c, ack); end
        end
        set_req(3, 15'h103);
        tick();
        req = '0;
        tick();
        checks++; if (rom_rd !== 1'b1 || rom_addr !== 15'h103) begin errs++; $display("FAIL mid_fresh_issue: got %b/%h want 1/0103", rom_rd, rom_addr); end
        tick();
        tick();
        checks++; if (ack !== 4'b1000 || rd(3) !== 8'h13) begin errs++; $display("FAIL mid_fresh_ack: got %b/%h want 1000/13", ack, rd(3)); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        preload();
        test_single();
        test_contention();
        test_rr();
        test_load();
        test_rereq();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
